fft_in_loader: RTL

//  Input-side writer for the 16-point FFT core memory. Accepts a valid/ready stream of

---
 rtl/fft_in_loader_pkg.sv | 21 ++
 rtl/fft_in_loader_bit_reverse.sv | 17 +
 rtl/fft_in_loader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fft_in_loader_pkg.sv
// Shared constants and types for the 16-point FFT input loader.
// Word/address widths, RAM region bases and the loader state encoding.
package fft_in_loader_pkg;

    localparam int FFT_WL     = 16;
    localparam int FFT_N_LOG2 = 4;
    localparam int FFT_N      = 1 << FFT_N_LOG2;
    localparam int FFT_AW     = 7;

    // RAM regions: input frame, working area, output frame.
    localparam logic [FFT_AW-1:0] FFT_IN_BASE   = 7'd0;
    localparam logic [FFT_AW-1:0] FFT_WORK_BASE = 7'd32;
    localparam logic [FFT_AW-1:0] FFT_OUT_BASE  = 7'd64;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } ld_state_e;

endpackage

// File: rtl/fft_in_loader_bit_reverse.sv
// Purely combinational W-bit bit reversal (bit i -> bit W-1-i).
// Ports: iD (W) input word, oQ (W) reversed word.
module bit_reverse #(
    parameter int W = 4
) (
    input  logic [W-1:0] iD,
    output logic [W-1:0] oQ
);

    always_comb begin
        oQ = '0;
        for (int i = 0; i < W; i++) begin
            oQ[i] = iD[W-1-i];
        end
    end

endmodule

// File: rtl/fft_in_loader.sv
// FFT input loader: writes a valid/ready sample stream into FFT RAM port A
// in bit-reversed (or natural) order, then pulses start and waits for done.
// Ports:
//   iCLK, iRSTn (async, low), iCLR (sync clear, highest priority)
//   iVALID, iDATA_re, iDATA_im / oREADY   - input sample stream
//   oWEN, oWADDR, oWDATA                  - RAM write port (registered)
//   oStart_INT                            - one-cycle FFT start pulse
//   iFFT_DONE / oBUSY                     - FFT completion / in-progress
module fft_in_loader
    import fft_in_loader_pkg::*;
#(
    parameter int              WL     = FFT_WL,
    parameter int              N_LOG2 = FFT_N_LOG2,
    parameter int              AW     = FFT_AW,
    parameter logic [AW-1:0]   BASE   = FFT_IN_BASE,
    parameter bit              BITREV = 1'b1
) (
    input  logic               iCLK,
    input  logic               iRSTn,
    input  logic               iCLR,
    input  logic               iVALID,
    input  logic [WL-1:0]      iDATA_re,
    input  logic [WL-1:0]      iDATA_im,
    output logic               oREADY,
    output logic               oWEN,
    output logic [AW-1:0]      oWADDR,
    output logic [2*WL-1:0]    oWDATA,
    output logic               oStart_INT,
    input  logic               iFFT_DONE,
    output logic               oBUSY
);

    ld_state_e             state_q, state_d;
    logic [N_LOG2-1:0]     cnt_q, cnt_d;
    logic                  wen_q, wen_d;
    logic [AW-1:0]         waddr_q, waddr_d;
    logic [2*WL-1:0]       wdata_q, wdata_d;
    logic                  start_q, start_d;

    logic [N_LOG2-1:0]     cnt_rev;
    logic [N_LOG2-1:0]     addr_off;
    logic                  accept;

    bit_reverse #(
        .W (N_LOG2)
    ) u_rev (
        .iD (cnt_q),
        .oQ (cnt_rev)
    );

    assign addr_off = BITREV ? cnt_rev : cnt_q;

    // Ready depends on state only, never on iVALID.
    assign oREADY = (state_q == LOAD);
    assign oBUSY  = (state_q == BUSY);
    assign accept = iVALID & oREADY;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        start_d = 1'b0;

        if (iCLR) begin
            state_d = LOAD;
            cnt_d   = '0;
            waddr_d = '0;
            wdata_d = '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (accept) begin
                        wen_d   = 1'b1;
                        // Wraps modulo 2^AW by construction.
                        waddr_d = BASE + AW'(addr_off);
                        wdata_d = {iDATA_re, iDATA_im};
                        if (&cnt_q) begin
                            cnt_d   = '0;
                            state_d = START;
                        end else begin
                            cnt_d = cnt_q + N_LOG2'(1);
                        end
                    end
                end
                // Start lands one cycle after the last write strobe.
                START: begin
                    start_d = 1'b1;
                    state_d = BUSY;
                end
                BUSY: begin
                    if (iFFT_DONE) begin
                        state_d = LOAD;
                    end
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            start_q <= start_d;
        end
    end

    assign oWEN       = wen_q;
    assign oWADDR     = waddr_q;
    assign oWDATA     = wdata_q;
    assign oStart_INT = start_q;

endmodule
